// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main control FSM for the Lab3 MIPS datapath.
// Walks IF/ID/EX/MEM/WB, decodes opcode in ID, drives PC/memory/ALU selects
// and the register-file strobes, stalls on mem_ready and counts retired
// instructions.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   opcode, funct, zero   IR fields and ALU zero flag (consumed by datapath)
//   mem_ready             memory handshake qualifying IF, MRD, MWR
//   pc_write..pcsource    Moore control strobes/selects decoded from state
//   illegal               one-cycle pulse in ID on an unknown opcode
//   inst_cnt              retired instruction counter (wraps)
//   state                 current state encoding for debug/display
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             memtoreg,
  output logic             regdst,
  output logic             write_reg,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MADR = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4,
    S_MWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7, S_BEQ = 4'd8, S_JMP = 4'd9,
    S_IEX = 4'd10, S_IWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b00_0000;
  localparam logic [5:0] OP_LW   = 6'b10_0011;
  localparam logic [5:0] OP_SW   = 6'b10_1011;
  localparam logic [5:0] OP_BEQ  = 6'b00_0100;
  localparam logic [5:0] OP_J    = 6'b00_0010;
  localparam logic [5:0] OP_ADDI = 6'b00_1000;
  localparam logic [5:0] OP_ANDI = 6'b00_1100;
  localparam logic [5:0] OP_ORI  = 6'b00_1101;
  localparam logic [5:0] OP_SLTI = 6'b00_1010;

  state_t cur, nxt;
  logic   retire;

  // funct is decoded by the ALU control (alu_op=2) and zero is gated with
  // pc_write_cond in the datapath; neither affects sequencing here.
  logic unused_ok;
  assign unused_ok = ^{funct, zero};

  assign state = cur;

  // An instruction retires on the final cycle of its sequence; sw only
  // retires once its write has been accepted.
  always_comb begin
    retire = 1'b0;
    case (cur)
      S_MWB, S_RWB, S_IWB, S_BEQ, S_JMP: retire = 1'b1;
      S_MWR:                             retire = mem_ready;
      default:                           retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_IF;
      inst_cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire) inst_cnt <= inst_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt           = cur;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    write_reg     = 1'b0;
    alusrc_a      = 1'b0;
    alusrc_b      = 2'd0;
    alu_op        = 2'd0;
    pcsource      = 2'd0;
    illegal       = 1'b0;
    case (cur)
      S_IF: begin
        mem_read = 1'b1;
        alusrc_b = 2'd1;
        // PC+4 and IR load only once the fetch has actually completed
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) nxt = S_ID;
      end
      S_ID: begin
        alusrc_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW:                    nxt = S_MADR;
          OP_R:                            nxt = S_REX;
          OP_BEQ:                          nxt = S_BEQ;
          OP_J:                            nxt = S_JMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_IEX;
          default: begin
            illegal = 1'b1;
            nxt     = S_IF;
          end
        endcase
      end
      S_MADR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        nxt      = (opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) nxt = S_MWB;
      end
      S_MWB: begin
        write_reg = 1'b1;
        memtoreg  = 1'b1;
        nxt       = S_IF;
      end
      S_MWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) nxt = S_IF;
      end
      S_REX: begin
        alusrc_a = 1'b1;
        alu_op   = 2'd2;
        nxt      = S_RWB;
      end
      S_RWB: begin
        write_reg = 1'b1;
        regdst    = 1'b1;
        nxt       = S_IF;
      end
      S_BEQ: begin
        alusrc_a      = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pcsource      = 2'd1;
        nxt           = S_IF;
      end
      S_JMP: begin
        pc_write = 1'b1;
        pcsource = 2'd2;
        nxt      = S_IF;
      end
      S_IEX: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        alu_op   = 2'd3;
        nxt      = S_IWB;
      end
      S_IWB: begin
        write_reg = 1'b1;
        nxt       = S_IF;
      end
      default: nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class with hand-computed
// state sequences, strobes and retire counts, including memory stalls,
// illegal opcodes and reset in the middle of a stalled store.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        memtoreg, regdst, write_reg, alusrc_a, illegal;
  logic [1:0]  alusrc_b, alu_op, pcsource;
  logic [31:0] inst_cnt;
  logic [3:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .memtoreg(memtoreg), .regdst(regdst), .write_reg(write_reg),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .alu_op(alu_op),
    .pcsource(pcsource), .illegal(illegal), .inst_cnt(inst_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then sample clear of it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    tick();
    rst = 1'b0;
    // reset state: IF decode
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_cnt", inst_cnt, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd1);
    chk("rst_write_reg", {31'd0, write_reg}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("if_ir_write", {31'd0, ir_write}, 32'd1);
    chk("if_pc_write", {31'd0, pc_write}, 32'd1);
    chk("if_alusrc_b", {30'd0, alusrc_b}, 32'd1);

    // R-type add: 0,1,6,7,0
    tick(); chk("r_id", {28'd0, state}, 32'd1);
    chk("id_alusrc_b", {30'd0, alusrc_b}, 32'd3);
    chk("id_illegal", {31'd0, illegal}, 32'd0);
    tick(); chk("r_rex", {28'd0, state}, 32'd6);
    chk("rex_alu_op", {30'd0, alu_op}, 32'd2);
    chk("rex_alusrc_a", {31'd0, alusrc_a}, 32'd1);
    chk("rex_write_reg", {31'd0, write_reg}, 32'd0);
    tick(); chk("r_rwb", {28'd0, state}, 32'd7);
    chk("rwb_write_reg", {31'd0, write_reg}, 32'd1);
    chk("rwb_regdst", {31'd0, regdst}, 32'd1);
    chk("rwb_memtoreg", {31'd0, memtoreg}, 32'd0);
    tick(); chk("r_if", {28'd0, state}, 32'd0);
    chk("r_cnt", inst_cnt, 32'd1);
    chk("r_if_write_reg", {31'd0, write_reg}, 32'd0);

    // lw with 3-cycle stall in MRD
    opcode = 6'h23;
    tick(); chk("lw_id", {28'd0, state}, 32'd1);
    tick(); chk("lw_madr", {28'd0, state}, 32'd2);
    chk("madr_alusrc_b", {30'd0, alusrc_b}, 32'd2);
    tick(); chk("lw_mrd", {28'd0, state}, 32'd3);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_mrd_hold", {28'd0, state}, 32'd3);
      chk("mrd_iord", {31'd0, iord}, 32'd1);
      chk("mrd_mem_read", {31'd0, mem_read}, 32'd1);
    end
    mem_ready = 1'b1;
    tick(); chk("lw_mwb", {28'd0, state}, 32'd4);
    chk("mwb_memtoreg", {31'd0, memtoreg}, 32'd1);
    chk("mwb_write_reg", {31'd0, write_reg}, 32'd1);
    chk("mwb_regdst", {31'd0, regdst}, 32'd0);
    tick(); chk("lw_if", {28'd0, state}, 32'd0);
    chk("lw_cnt", inst_cnt, 32'd2);

    // beq then j
    opcode = 6'h04; zero = 1'b1;
    tick(); chk("beq_id", {28'd0, state}, 32'd1);
    tick(); chk("beq_st", {28'd0, state}, 32'd8);
    chk("beq_pwc", {31'd0, pc_write_cond}, 32'd1);
    chk("beq_pcsrc", {30'd0, pcsource}, 32'd1);
    chk("beq_alu_op", {30'd0, alu_op}, 32'd1);
    tick(); chk("beq_if", {28'd0, state}, 32'd0);
    opcode = 6'h02;
    tick(); chk("j_id", {28'd0, state}, 32'd1);
    tick(); chk("j_st", {28'd0, state}, 32'd9);
    chk("j_pc_write", {31'd0, pc_write}, 32'd1);
    chk("j_pcsrc", {30'd0, pcsource}, 32'd2);
    tick(); chk("j_if", {28'd0, state}, 32'd0);
    chk("bj_cnt", inst_cnt, 32'd4);

    // illegal opcode
    opcode = 6'h3F;
    tick(); chk("ill_id", {28'd0, state}, 32'd1);
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    tick(); chk("ill_if", {28'd0, state}, 32'd0);
    chk("ill_clear", {31'd0, illegal}, 32'd0);
    chk("ill_cnt", inst_cnt, 32'd4);

    // IF stall: no IR/PC load while memory busy
    opcode = 6'h08; mem_ready = 1'b0;
    tick(); chk("ifst_state", {28'd0, state}, 32'd0);
    chk("ifst_ir_write", {31'd0, ir_write}, 32'd0);
    chk("ifst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("ifst_mem_read", {31'd0, mem_read}, 32'd1);
    mem_ready = 1'b1;

    // addi: 0,1,10,11,0
    tick(); chk("addi_id", {28'd0, state}, 32'd1);
    tick(); chk("addi_iex", {28'd0, state}, 32'd10);
    chk("iex_alu_op", {30'd0, alu_op}, 32'd3);
    chk("iex_alusrc_b", {30'd0, alusrc_b}, 32'd2);
    tick(); chk("addi_iwb", {28'd0, state}, 32'd11);
    chk("iwb_write_reg", {31'd0, write_reg}, 32'd1);
    chk("iwb_regdst", {31'd0, regdst}, 32'd0);
    tick(); chk("addi_if", {28'd0, state}, 32'd0);
    chk("addi_cnt", inst_cnt, 32'd5);

    // sw stalled in MWR, then reset mid-stall
    opcode = 6'h2B;
    tick(); chk("sw_id", {28'd0, state}, 32'd1);
    tick(); chk("sw_madr", {28'd0, state}, 32'd2);
    tick(); chk("sw_mwr", {28'd0, state}, 32'd5);
    chk("mwr_mem_write", {31'd0, mem_write}, 32'd1);
    chk("mwr_iord", {31'd0, iord}, 32'd1);
    mem_ready = 1'b0;
    tick(); chk("sw_hold", {28'd0, state}, 32'd5);
    chk("sw_hold_mw", {31'd0, mem_write}, 32'd1);
    chk("sw_hold_cnt", inst_cnt, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    chk("rstmid_state", {28'd0, state}, 32'd0);
    chk("rstmid_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rstmid_write_reg", {31'd0, write_reg}, 32'd0);
    chk("rstmid_cnt", inst_cnt, 32'd0);

    // sw completing with mem_ready: 0,1,2,5,0 and retires
    tick(); chk("sw2_id", {28'd0, state}, 32'd1);
    tick(); chk("sw2_madr", {28'd0, state}, 32'd2);
    tick(); chk("sw2_mwr", {28'd0, state}, 32'd5);
    tick(); chk("sw2_if", {28'd0, state}, 32'd0);
    chk("sw2_cnt", inst_cnt, 32'd1);

    // rst wins over mem_ready while in IF
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst_pri_state", {28'd0, state}, 32'd0);
    chk("rst_pri_cnt", inst_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
